// File: rtl/accum_cpu_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states and decode helpers.
package accum_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JNC  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic is_jump(input logic [3:0] op);
        return op inside {OP_JMP, OP_JC, OP_JNC, OP_JZ};
    endfunction

    function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
        case (op)
            OP_JMP:  return 1'b1;
            OP_JC:   return c;
            OP_JNC:  return !c;
            OP_JZ:   return z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU: add/sub with carry-out, bitwise AND/OR/XOR.
module accum_alu
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            // carry=1 means no borrow
            OP_SUB: {carry, result} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator processor core: loadable program memory, data memory, A/B regs,
// carry/zero flags, fetch/execute FSM and a valid/ready input port.
module accum_cpu_core
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PM_AW  = 4,
    parameter int DM_AW  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    prog_we,
    input  logic [PM_AW-1:0]        prog_addr,
    input  logic [OPC_W+DATA_W-1:0] prog_data,
    input  logic                    run,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic [PM_AW-1:0]        pc,
    output logic                    busy,
    output logic                    halted
);

    localparam int IW = OPC_W + DATA_W;

    logic [IW-1:0]     pm [2**PM_AW];
    logic [DATA_W-1:0] dm [2**DM_AW];

    state_t            state, state_nxt;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] a_q, b_q;
    logic              c_q, z_q;

    logic [3:0]        opc;
    logic [DATA_W-1:0] opnd;
    logic [PM_AW-1:0]  jmp_tgt, pc_inc;
    logic [DM_AW-1:0]  dm_addr;
    logic              prog_open, in_wait;
    logic [DATA_W-1:0] alu_res, a_nxt;
    logic              alu_c, a_wr;

    assign opc       = ir[IW-1 -: OPC_W];
    assign opnd      = ir[DATA_W-1:0];
    assign jmp_tgt   = opnd[PM_AW-1:0];
    assign dm_addr   = opnd[DM_AW-1:0];
    assign pc_inc    = pc + PM_AW'(1);
    assign prog_open = (state == ST_IDLE) || (state == ST_HALT);
    assign in_wait   = (opc == OP_IN) && !in_valid;

    accum_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (opc),
        .result (alu_res),
        .carry  (alu_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        halted    = 1'b0;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: if (run) state_nxt = ST_FETCH;
            ST_FETCH: begin
                busy      = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                busy     = 1'b1;
                in_ready = (opc == OP_IN);
                if (opc == OP_HALT) state_nxt = ST_HALT;
                else if (!in_wait)  state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every write to A goes through here so Z tracks it in one place.
    always_comb begin
        a_wr  = 1'b0;
        a_nxt = alu_res;
        if (state == ST_EXEC) begin
            if (is_alu_op(opc)) a_wr = 1'b1;
            case (opc)
                OP_LD: begin
                    a_wr  = 1'b1;
                    a_nxt = dm[dm_addr];
                end
                OP_LDI: begin
                    a_wr  = 1'b1;
                    a_nxt = opnd;
                end
                OP_IN: begin
                    a_wr  = in_valid;
                    a_nxt = in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: if (run) pc <= '0;
                ST_FETCH: ir <= pm[pc];
                ST_EXEC: begin
                    if (a_wr) begin
                        a_q <= a_nxt;
                        z_q <= (a_nxt == '0);
                    end
                    if (opc == OP_ADD || opc == OP_SUB) c_q <= alu_c;
                    if (opc == OP_MOV) b_q <= a_q;
                    if (opc == OP_OUT) begin
                        out_data  <= a_q;
                        out_valid <= 1'b1;
                    end
                    if (is_jump(opc))
                        pc <= jump_taken(opc, c_q, z_q) ? jmp_tgt : pc_inc;
                    else if (opc != OP_HALT && !in_wait)
                        pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end

    // Memories are not reset; a reset forces IDLE so no ST write can land after it.
    always_ff @(posedge clk) begin
        if (prog_open && prog_we) pm[prog_addr] <= prog_data;
        if (state == ST_EXEC && opc == OP_ST) dm[dm_addr] <= a_q;
    end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Bench for accum_cpu_core: instruction-level reference model checked every cycle,
// directed programs with literal expectations, then randomized programs and port traffic.
module tb_accum_cpu_core;

    localparam int DW = 8;
    localparam int PAW = 4;
    localparam int DAW = 4;
    localparam int IW = 12;
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [PAW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          run = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, out_valid, busy, halted;
    logic [DW-1:0] out_data;
    logic [PAW-1:0] pc;

    always #5 clk = ~clk;

    accum_cpu_core #(.DATA_W(DW), .PM_AW(PAW), .DM_AW(DAW)) dut (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .pc(pc), .busy(busy), .halted(halted)
    );

    int n_chk = 0;
    int n_pass = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (one instruction per FETCH/EXEC pair) ----------------
    logic [IW-1:0] m_pm [16];
    int m_dm [16];
    int mA, mB, mC, mZ, m_pc, m_mode, m_ir, m_out, m_outv;

    function automatic logic [IW-1:0] ins(input int op, input int opd);
        return {op[3:0], opd[7:0]};
    endfunction

    task automatic set_a(input int v);
        mA = v & 255;
        mZ = (mA == 0) ? 1 : 0;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 0; m_ir = 0;
        mA = 0; mB = 0; mC = 0; mZ = 0; m_out = 0; m_outv = 0;
    endtask

    task automatic model_step();
        int op, opd, s, nxt;
        m_outv = 0;
        case (m_mode)
            M_IDLE, M_HALT: begin
                if (prog_we) m_pm[prog_addr] = prog_data;
                if (run) begin m_mode = M_FETCH; m_pc = 0; end
            end
            M_FETCH: begin
                m_ir = int'(m_pm[m_pc]);
                m_mode = M_EXEC;
            end
            default: begin
                op = m_ir >> 8;
                opd = m_ir & 255;
                nxt = (m_pc + 1) % 16;
                m_mode = M_FETCH;
                case (op)
                    0: begin s = mA + mB; mC = (s >> 8) & 1; set_a(s); end
                    1: begin s = mA + (255 - mB) + 1; mC = (s >> 8) & 1; set_a(s); end
                    2: set_a(mA & mB);
                    3: set_a(mA | mB);
                    14: set_a(mA ^ mB);
                    4: set_a(m_dm[opd % 16]);
                    5: m_dm[opd % 16] = mA;
                    6: set_a(opd);
                    7: begin m_out = mA; m_outv = 1; end
                    8: mB = mA;
                    9: nxt = opd % 16;
                    10: if (mC != 0) nxt = opd % 16;
                    11: if (mC == 0) nxt = opd % 16;
                    12: if (mZ != 0) nxt = opd % 16;
                    13: if (in_valid) set_a(int'(in_data));
                        else begin nxt = m_pc; m_mode = M_EXEC; end
                    default: begin nxt = m_pc; m_mode = M_HALT; end
                endcase
                m_pc = nxt;
            end
        endcase
    endtask

    always @(posedge clk) if (reset_n) model_step();

    always @(negedge clk) begin
        if (reset_n) begin
            chk("pc", pc, m_pc);
            chk("busy", busy, (m_mode == M_FETCH || m_mode == M_EXEC) ? 1 : 0);
            chk("halted", halted, (m_mode == M_HALT) ? 1 : 0);
            chk("in_ready", in_ready, (m_mode == M_EXEC && (m_ir >> 8) == 13) ? 1 : 0);
            chk("out_data", out_data, m_out);
            chk("out_valid", out_valid, m_outv);
            if (out_valid === 1'b1) pulses++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [IW-1:0] p[$]);
        foreach (p[i]) begin
            prog_we = 1'b1;
            prog_addr = PAW'(i);
            prog_data = p[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halt(input int max, output int n);
        n = 0;
        while (halted !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("halt_reached", halted, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] prog[$];
        int n;
        model_reset();
        tick();
        do_reset();

        // ADD and OUT, with cycle-count pin
        prog = {ins(6, 5), ins(8, 0), ins(6, 3), ins(0, 0), ins(7, 0), ins(15, 0)};
        load(prog);
        pulses = 0;
        start();
        wait_halt(100, n);
        chk("t1_cycles", n, 12);
        chk("t1_out", out_data, 8'h08);
        chk("t1_pulses", pulses, 1);
        chk("t1_pc", pc, 5);
        chk("t1_model_a", mA, 8'h08);
        chk("t1_model_cz", {mC[0], mZ[0]}, 0);

        // carry out of ADD, JC taken skips OUT
        prog = {ins(6, 8'hF0), ins(8, 0), ins(6, 8'h20), ins(0, 0), ins(10, 6), ins(7, 0), ins(15, 0)};
        load(prog);
        pulses = 0;
        start();
        wait_halt(100, n);
        chk("t2_pulses", pulses, 0);
        chk("t2_pc", pc, 6);
        chk("t2_model_a", mA, 8'h10);
        chk("t2_model_c", mC, 1);

        // SUB to zero, JZ taken
        prog = {ins(6, 7), ins(8, 0), ins(1, 0), ins(12, 5), ins(7, 0), ins(15, 0)};
        load(prog);
        pulses = 0;
        start();
        wait_halt(100, n);
        chk("t3_pulses", pulses, 0);
        chk("t3_pc", pc, 5);
        chk("t3_model_a", mA, 0);
        chk("t3_model_zc", {mZ[0], mC[0]}, 2'b11);

        // ST/LD through DM, DM survives reset
        prog = {ins(6, 8'hA5), ins(5, 3), ins(6, 0), ins(4, 3), ins(7, 0), ins(15, 0)};
        load(prog);
        start();
        wait_halt(100, n);
        chk("t4_out", out_data, 8'hA5);
        do_reset();
        prog = {ins(4, 3), ins(7, 0), ins(15, 0)};
        load(prog);
        start();
        wait_halt(100, n);
        chk("t4_dm_kept", out_data, 8'hA5);

        // IN stall then handshake
        prog = {ins(13, 0), ins(7, 0), ins(15, 0)};
        load(prog);
        start();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_ready", in_ready, 1);
            chk("t5_stall_pc", pc, 0);
            tick();
        end
        in_valid = 1'b1;
        in_data = 8'h3C;
        chk("t5_ready_hs", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_ready_drop", in_ready, 0);
        wait_halt(100, n);
        chk("t5_out", out_data, 8'h3C);

        // 16 MOVs: pc wraps; prog_we during run ignored
        prog = {};
        for (int i = 0; i < 16; i++) prog.push_back(ins(8, 0));
        load(prog);
        start();
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = ins(15, 0);
        tick();
        prog_we = 1'b0;
        n = 0;
        while (pc !== 4'd15 && n < 100) begin tick(); n++; end
        chk("t6_reach15", pc, 15);
        tick(); tick();
        chk("t6_wrap", pc, 0);
        repeat (40) tick();
        chk("t6_pm_unchanged", halted, 0);
        do_reset();

        // reset during EXEC of ST leaves DM untouched
        prog = {ins(6, 8'h5A), ins(5, 9), ins(15, 0)};
        load(prog);
        start();
        wait_halt(100, n);
        prog = {ins(6, 8'h77), ins(5, 9), ins(15, 0)};
        load(prog);
        start();
        tick(); tick(); tick();
        do_reset();
        prog = {ins(4, 9), ins(7, 0), ins(15, 0)};
        load(prog);
        start();
        wait_halt(100, n);
        chk("t7_dm_unwritten", out_data, 8'h5A);

        // fill DM with known values before random programs read it
        for (int a = 0; a < 16; a++) begin
            prog = {ins(6, int'($urandom_range(0, 255))), ins(5, a), ins(15, 0)};
            load(prog);
            start();
            wait_halt(100, n);
        end

        // random programs with random port traffic
        for (int r = 0; r < 20; r++) begin
            prog = {};
            for (int i = 0; i < 16; i++)
                prog.push_back(ins(int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
            load(prog);
            start();
            for (int c = 0; c < 120; c++) begin
                in_valid  = ($urandom_range(0, 3) == 0);
                in_data   = DW'($urandom_range(0, 255));
                prog_we   = ($urandom_range(0, 7) == 0);
                prog_addr = PAW'($urandom_range(0, 15));
                prog_data = IW'($urandom_range(0, 4095));
                run       = ($urandom_range(0, 15) == 0);
                tick();
            end
            in_valid = 1'b0; prog_we = 1'b0; run = 1'b0;
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
